// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Issues req/ack fetches at CurrentPC and holds the captured word for decode; misalignment and timeouts raise a sticky fault.
module pc_fetch_unit #(
  parameter int TIMEOUT = 16,
  parameter int TCNT_W  = 5
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] StartPC,
  input  logic [63:0] NextPC,
  input  logic        Advance,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [63:0] CurrentPC,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic        Fault,
  output logic [1:0]  FaultCode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  // Counter value seen in the last ackless FETCH cycle before giving up.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t              state_reg, state_next;
  logic [63:0]         pc_reg, pc_next;
  logic [31:0]         instr_reg, instr_next;
  logic                valid_reg, valid_next;
  logic                req_reg, req_next;
  logic                fault_reg, fault_next;
  logic [1:0]          code_reg, code_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_reg <= S_IDLE;
      pc_reg    <= StartPC;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      req_reg   <= 1'b0;
      fault_reg <= 1'b0;
      code_reg  <= FC_NONE;
      tcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      req_reg   <= req_next;
      fault_reg <= fault_next;
      code_reg  <= code_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    req_next   = req_reg;
    fault_next = fault_reg;
    code_next  = code_reg;
    tcnt_next  = tcnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (pc_reg[1:0] != 2'b00) begin
          state_next = S_FAULT;
          fault_next = 1'b1;
          code_next  = FC_MISALIGN;
        end else begin
          state_next = S_FETCH;
          req_next   = 1'b1;
          tcnt_next  = '0;
        end
      end

      S_FETCH: begin
        // An ack on the final allowed cycle still completes the fetch.
        if (IMemAck) begin
          state_next = S_VALID;
          instr_next = IMemData;
          valid_next = 1'b1;
          req_next   = 1'b0;
        end else if (TIMEOUT_EN && (tcnt_reg == TCNT_LAST)) begin
          state_next = S_FAULT;
          fault_next = 1'b1;
          code_next  = FC_TIMEOUT;
          req_next   = 1'b0;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end

      S_VALID: begin
        if (Advance) begin
          // The bad target is still loaded so it is visible for debug.
          pc_next    = NextPC;
          valid_next = 1'b0;
          if (NextPC[1:0] != 2'b00) begin
            state_next = S_FAULT;
            fault_next = 1'b1;
            code_next  = FC_MISALIGN;
          end else begin
            state_next = S_FETCH;
            req_next   = 1'b1;
            tcnt_next  = '0;
          end
        end
      end

      S_FAULT: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
      end

      default: begin
        state_next = S_FAULT;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign IMemReq     = req_reg;
  assign IMemAddr    = pc_reg;
  assign CurrentPC   = pc_reg;
  assign Instruction = instr_reg;
  assign InstrValid  = valid_reg;
  assign Fault       = fault_reg;
  assign FaultCode   = code_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a behavioural fetch model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_pc_fetch_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [63:0] start_pc, next_pc;
  logic        advance, ack;
  logic [31:0] data;
  logic        IMemReq, InstrValid, Fault;
  logic [63:0] IMemAddr, CurrentPC;
  logic [31:0] Instruction;
  logic [1:0]  FaultCode;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit #(.TIMEOUT(TO), .TCNT_W(3)) dut (
    .CLK(clk), .Reset_L(rst_l), .StartPC(start_pc), .NextPC(next_pc),
    .Advance(advance), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(ack), .IMemData(data), .CurrentPC(CurrentPC),
    .Instruction(Instruction), .InstrValid(InstrValid),
    .Fault(Fault), .FaultCode(FaultCode)
  );

  always #5 clk = ~clk;

  // Model: tracks whether a fetch is outstanding, how long it has waited,
  // and whether decode holds a word, from the behavioural rules alone.
  logic        m_known = 1'b0;
  logic        m_idle, m_req, m_valid, m_fault;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [1:0]  m_code;
  int          m_wait;

  always @(posedge clk) begin
    if (!rst_l) begin
      m_known <= 1'b1;
      m_idle  <= 1'b1;
      m_pc    <= start_pc;
      m_instr <= '0;
      m_valid <= 1'b0;
      m_req   <= 1'b0;
      m_fault <= 1'b0;
      m_code  <= 2'b00;
      m_wait  <= 0;
    end else if (m_known && !m_fault) begin
      if (m_idle) begin
        m_idle <= 1'b0;
        if (m_pc[1:0] != 2'b00) begin
          m_fault <= 1'b1;
          m_code  <= 2'b01;
        end else begin
          m_req  <= 1'b1;
          m_wait <= 0;
        end
      end else if (m_req) begin
        if (ack) begin
          m_instr <= data;
          m_valid <= 1'b1;
          m_req   <= 1'b0;
        end else if (m_wait + 1 == TO) begin
          m_fault <= 1'b1;
          m_code  <= 2'b10;
          m_req   <= 1'b0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_valid && advance) begin
        m_pc    <= next_pc;
        m_valid <= 1'b0;
        if (next_pc[1:0] != 2'b00) begin
          m_fault <= 1'b1;
          m_code  <= 2'b01;
        end else begin
          m_req  <= 1'b1;
          m_wait <= 0;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp, input bit verbose);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp(name, act, exp, 1'b1);
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      cmp("cyc_pc",    CurrentPC,   m_pc,    1'b0);
      cmp("cyc_addr",  IMemAddr,    m_pc,    1'b0);
      cmp("cyc_req",   IMemReq,     m_req,   1'b0);
      cmp("cyc_valid", InstrValid,  m_valid, 1'b0);
      cmp("cyc_instr", Instruction, m_instr, 1'b0);
      cmp("cyc_fault", Fault,       m_fault, 1'b0);
      cmp("cyc_code",  FaultCode,   m_code,  1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_l = 1'b0; start_pc = 64'h0; next_pc = 64'h0;
    advance = 1'b0; ack = 1'b0; data = 32'h0;

    // Reset, one IDLE cycle, then fetch of address 0
    cyc(2);
    lit("rst_pc", CurrentPC, 64'h0);
    lit("rst_req", IMemReq, 0);
    lit("rst_valid", InstrValid, 0);
    lit("rst_fault", Fault, 0);
    lit("rst_instr", Instruction, 0);
    rst_l = 1'b1;
    cyc(1);
    lit("fetch_req", IMemReq, 1);
    lit("fetch_addr", IMemAddr, 64'h0);
    data = 32'hDEADBEEF;
    cyc(3);
    lit("wait3_req", IMemReq, 1);
    lit("wait3_fault", Fault, 0);
    ack = 1'b1; data = 32'hF84003E9;
    cyc(1);
    ack = 1'b0;
    lit("ack_instr", Instruction, 32'hF84003E9);
    lit("ack_valid", InstrValid, 1);
    lit("ack_req", IMemReq, 0);

    // Sequential advance to 4
    advance = 1'b1; next_pc = 64'h4;
    cyc(1);
    advance = 1'b0;
    lit("adv_pc", CurrentPC, 64'h4);
    lit("adv_req", IMemReq, 1);
    lit("adv_valid", InstrValid, 0);
    ack = 1'b1; data = 32'h91000421;
    cyc(1);
    ack = 1'b0;

    // Stall in VALID then take a branch to 0x40
    next_pc = 64'h40;
    cyc(10);
    lit("stall_pc", CurrentPC, 64'h4);
    lit("stall_valid", InstrValid, 1);
    lit("stall_instr", Instruction, 32'h91000421);
    advance = 1'b1;
    cyc(1);
    advance = 1'b0;
    lit("br_addr", IMemAddr, 64'h40);
    lit("br_req", IMemReq, 1);
    cyc(1);
    ack = 1'b1; data = 32'h12345678;
    cyc(1);
    ack = 1'b0;
    lit("br_instr", Instruction, 32'h12345678);

    // Timeout: four FETCH cycles with no ack
    advance = 1'b1; next_pc = 64'h8;
    cyc(1);
    advance = 1'b0;
    cyc(3);
    lit("to3_fault", Fault, 0);
    lit("to3_req", IMemReq, 1);
    cyc(1);
    lit("to4_fault", Fault, 1);
    lit("to4_code", FaultCode, 2'b10);
    lit("to4_req", IMemReq, 0);
    lit("to4_pc", CurrentPC, 64'h8);
    ack = 1'b1; advance = 1'b1;
    cyc(2);
    ack = 1'b0; advance = 1'b0;
    lit("to_sticky_valid", InstrValid, 0);
    lit("to_sticky_code", FaultCode, 2'b10);

    // Misaligned start PC
    rst_l = 1'b0; start_pc = 64'h2;
    cyc(1);
    lit("mstart_rst_fault", Fault, 0);
    rst_l = 1'b1;
    cyc(1);
    lit("mstart_fault", Fault, 1);
    lit("mstart_code", FaultCode, 2'b01);
    lit("mstart_req", IMemReq, 0);

    // Misaligned NextPC
    rst_l = 1'b0; start_pc = 64'h200;
    cyc(1);
    rst_l = 1'b1;
    cyc(1);
    ack = 1'b1; data = 32'hAAAA5555;
    cyc(1);
    ack = 1'b0;
    lit("mnext_valid", InstrValid, 1);
    next_pc = 64'h42; advance = 1'b1;
    cyc(1);
    lit("mnext_fault", Fault, 1);
    lit("mnext_code", FaultCode, 2'b01);
    lit("mnext_pc", CurrentPC, 64'h42);
    lit("mnext_req", IMemReq, 0);
    ack = 1'b1; next_pc = 64'h80;
    cyc(3);
    ack = 1'b0; advance = 1'b0;
    lit("mnext_hold_pc", CurrentPC, 64'h42);
    lit("mnext_hold_req", IMemReq, 0);

    // Reset during FETCH with a coincident ack
    rst_l = 1'b0; start_pc = 64'h300;
    cyc(1);
    rst_l = 1'b1;
    cyc(1);
    lit("mid_req", IMemReq, 1);
    lit("mid_addr", IMemAddr, 64'h300);
    cyc(1);
    rst_l = 1'b0; start_pc = 64'h100; ack = 1'b1; data = 32'hCAFEF00D;
    cyc(1);
    ack = 1'b0;
    lit("mid_valid", InstrValid, 0);
    lit("mid_pc", CurrentPC, 64'h100);
    lit("mid_fault", Fault, 0);
    lit("mid_instr", Instruction, 0);
    rst_l = 1'b1;
    cyc(1);
    lit("mid_refetch_req", IMemReq, 1);
    lit("mid_refetch_addr", IMemAddr, 64'h100);
    ack = 1'b1; data = 32'h0BADC0DE;
    cyc(1);
    ack = 1'b0;
    lit("mid_refetch_instr", Instruction, 32'h0BADC0DE);

    // Best-case throughput: advance and immediate ack
    advance = 1'b1; next_pc = 64'h104;
    cyc(1);
    advance = 1'b0; ack = 1'b1; data = 32'h13579BDF;
    cyc(1);
    ack = 1'b0;
    lit("fast_pc", CurrentPC, 64'h104);
    lit("fast_valid", InstrValid, 1);
    lit("fast_instr", Instruction, 32'h13579BDF);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
